// File: rtl/lifo_fifo_buffer_if.sv
// Producer/consumer bus of the dual-mode FIFO/LIFO buffer.
// The slave side is the buffer. The master side is the client that drives requests.
interface lifo_fifo_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             mode;
  logic             flush;
  logic             wren;
  logic [WIDTH-1:0] wr_data;
  logic             ren;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             act_mode;
  logic             overflow;
  logic             underflow;
  logic             mode_err;

  modport master (
    output mode, flush, wren, wr_data, ren, clr_err,
    input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           act_mode, overflow, underflow, mode_err
  );

  modport slave (
    input  mode, flush, wren, wr_data, ren, clr_err,
    output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           act_mode, overflow, underflow, mode_err
  );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// Single-clock buffer that works as a FIFO queue or a LIFO stack, selected at run time.
// It has registered read data, occupancy flags and sticky error flags.
module lifo_fifo_buffer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic               clk,
  input logic               rst_n,
  lifo_fifo_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {MODE_FIFO = 1'b0, MODE_LIFO = 1'b1} mode_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  mode_e            r_mode;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_mode_err;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ovf;
  logic             w_udf;
  logic             w_merr;
  logic             w_mode_ld;
  logic [AW-1:0]    w_top;
  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;
  logic [CW-1:0]    w_count_nxt;

  // Acceptance, error detection and addressing for this cycle
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CW'(DEPTH));
    w_wr_acc  = !bus.flush && bus.wren && (!w_full || bus.ren);
    w_rd_acc  = !bus.flush && bus.ren && !w_empty;
    w_ovf     = !bus.flush && bus.wren && !bus.ren && w_full;
    w_udf     = !bus.flush && bus.ren && w_empty;
    w_merr    = !bus.flush && (mode_e'(bus.mode) != r_mode) && !w_empty;
    w_mode_ld = !bus.flush && w_empty && !w_wr_acc;
    w_top     = AW'(r_count - CW'(1));
    w_widx    = r_wptr;
    w_ridx    = r_rptr;
    // A stack push with a simultaneous pop replaces the top slot.
    if (r_mode == MODE_LIFO) begin
      w_widx = w_rd_acc ? w_top : AW'(r_count);
      w_ridx = w_top;
    end
    w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    if (bus.flush) begin
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_widx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_mode         <= MODE_FIFO;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_mode_err     <= 1'b0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= (AF_LEVEL == 0);
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_rd_valid     <= w_rd_acc;
      r_full         <= (w_count_nxt == CW'(DEPTH));
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
      r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));
      if (w_rd_acc) begin
        r_rd_data <= r_mem[w_ridx];
      end
      if (w_mode_ld) begin
        r_mode <= mode_e'(bus.mode);
      end
      if (bus.flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (r_mode == MODE_FIFO) begin
          r_wptr <= r_wptr + AW'(w_wr_acc);
          r_rptr <= r_rptr + AW'(w_rd_acc);
        end
        // A new error in the same cycle as a clear keeps the flag set.
        r_overflow  <= w_ovf  || (r_overflow  && !bus.clr_err);
        r_underflow <= w_udf  || (r_underflow && !bus.clr_err);
        r_mode_err  <= w_merr || (r_mode_err  && !bus.clr_err);
      end
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.act_mode     = r_mode;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.mode_err     = r_mode_err;
endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Self-checking bench for lifo_fifo_buffer (WIDTH=8, DEPTH=8).
// It runs directed and random steps against a queue-based reference model.
module tb_lifo_fifo_buffer;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  lifo_fifo_buffer_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_if ();

  lifo_fifo_buffer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_q [$];
  logic       m_mode;
  logic       m_ovf, m_udf, m_merr;
  logic [7:0] m_rd;
  logic       m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_merr = 1'b0;
    m_rd   = 8'h00;
    m_vld  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int c;
    c = m_q.size();
    chk({tag, ".count"},     32'(bus_if.count),        32'(c));
    chk({tag, ".empty"},     32'(bus_if.empty),        32'(c == 0));
    chk({tag, ".full"},      32'(bus_if.full),         32'(c == DEPTH));
    chk({tag, ".afull"},     32'(bus_if.almost_full),  32'(c >= DEPTH - 2));
    chk({tag, ".aempty"},    32'(bus_if.almost_empty), 32'(c <= 1));
    chk({tag, ".rd_valid"},  32'(bus_if.rd_valid),     32'(m_vld));
    chk({tag, ".rd_data"},   32'(bus_if.rd_data),      32'(m_rd));
    chk({tag, ".act_mode"},  32'(bus_if.act_mode),     32'(m_mode));
    chk({tag, ".overflow"},  32'(bus_if.overflow),     32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus_if.underflow),    32'(m_udf));
    chk({tag, ".mode_err"},  32'(bus_if.mode_err),     32'(m_merr));
  endtask

  // Apply one cycle of requests, advance the model, then check after the edge
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re,
                       input logic md, input logic fl, input logic cl, input string tag);
    logic empty, full, ovf, udf, merr;
    bus_if.wren    = we;
    bus_if.wr_data = wd;
    bus_if.ren     = re;
    bus_if.mode    = md;
    bus_if.flush   = fl;
    bus_if.clr_err = cl;
    m_vld = 1'b0;
    if (fl) begin
      m_q.delete();
    end else begin
      empty = (m_q.size() == 0);
      full  = (m_q.size() == DEPTH);
      ovf   = we && !re && full;
      udf   = re && empty;
      merr  = (md != m_mode) && !empty;
      if (re && !empty) begin
        m_vld = 1'b1;
        m_rd  = m_mode ? m_q[$] : m_q[0];
      end
      if (we && re && !empty) begin
        if (m_mode) m_q[m_q.size() - 1] = wd;
        else begin
          void'(m_q.pop_front());
          m_q.push_back(wd);
        end
      end else begin
        if (we && !full) m_q.push_back(wd);
        if (re && !empty) begin
          if (m_mode) void'(m_q.pop_back());
          else        void'(m_q.pop_front());
        end
      end
      if (empty && !we) m_mode = md;
      m_ovf  = ovf  || (m_ovf  && !cl);
      m_udf  = udf  || (m_udf  && !cl);
      m_merr = merr || (m_merr && !cl);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input logic md, input string tag);
    cycle(1'b0, 8'h00, 1'b0, md, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [7:0] wv;
    logic       cur_mode;
    bus_if.wren = 1'b0; bus_if.wr_data = '0; bus_if.ren = 1'b0;
    bus_if.mode = 1'b0; bus_if.flush = 1'b0; bus_if.clr_err = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIFO fill and drain
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0, 1'b0, "fifo_wr");
      if (i == 6) chk("fifo_af_at6", 32'(bus_if.almost_full), 32'd1);
    end
    chk("fifo_full", 32'(bus_if.full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "fifo_rd");
      chk("fifo_rd_order", 32'(bus_if.rd_data), 32'(i * 8'h11));
    end
    idle(1'b0, "fifo_after");
    chk("fifo_empty_end", 32'(bus_if.empty), 32'd1);

    // LIFO push/pop, underflow, clear
    idle(1'b1, "to_lifo");
    chk("lifo_mode", 32'(bus_if.act_mode), 32'd1);
    cycle(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b0, "lifo_push");
    cycle(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 1'b0, "lifo_push");
    cycle(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, "lifo_push");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "lifo_pop");
      chk("lifo_pop_order", 32'(bus_if.rd_data), 32'(8'hA3 - 8'(i)));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "lifo_udf");
    chk("lifo_udf_flag", 32'(bus_if.underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "lifo_clr");
    chk("lifo_udf_clr", 32'(bus_if.underflow), 32'd0);

    // FIFO wrap with four entries in flight
    idle(1'b0, "to_fifo");
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0, "wrap_fill");
    for (int k = 4; k < 24; k++) begin
      cycle(1'b1, 8'(k), 1'b1, 1'b0, 1'b0, 1'b0, "wrap_rw");
      chk("wrap_lag", 32'(bus_if.rd_data), 32'(k - 4));
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "wrap_flush");

    // LIFO full: simultaneous push/pop, overflow
    idle(1'b1, "to_lifo2");
    for (int k = 1; k <= 8; k++) cycle(1'b1, 8'(k), 1'b0, 1'b1, 1'b0, 1'b0, "lf_push");
    cycle(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, "lf_swap");
    chk("lf_swap_old_top", 32'(bus_if.rd_data), 32'h08);
    chk("lf_swap_count", 32'(bus_if.count), 32'd8);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, "lf_ovf");
    chk("lf_ovf_flag", 32'(bus_if.overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "lf_pop");
    chk("lf_pop_new_top", 32'(bus_if.rd_data), 32'hFF);

    // Mode change rules
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, "m_flush");
    idle(1'b0, "m_to_fifo");
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b0, 1'b0, "m_fill");
    idle(1'b1, "m_req_lifo");
    chk("m_hold_mode", 32'(bus_if.act_mode), 32'd0);
    chk("m_err_flag", 32'(bus_if.mode_err), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, "m_flush2");
    idle(1'b1, "m_switch");
    chk("m_switched", 32'(bus_if.act_mode), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "m_clr");

    // Random traffic
    cur_mode = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 29) == 0) cur_mode = ~cur_mode;
      wv = 8'($urandom);
      cycle(1'($urandom_range(0, 1)), wv, 1'($urandom_range(0, 1)), cur_mode,
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) == 0), "rand");
    end

    // Asynchronous reset mid-operation
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "r_flush");
    idle(1'b0, "r_fifo");
    idle(1'b0, "r_fifo2");
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'h60 + k), 1'b0, 1'b0, 1'b0, 1'b0, "r_fill");
    bus_if.wren = 1'b0;
    bus_if.ren  = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    bus_if.ren = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "rst_rd_empty");
    chk("rst_rd_udf", 32'(bus_if.underflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lifo_fifo_buffer.md
Name: lifo_fifo_buffer

Overview:
- Parametrised single-clock buffer that operates as either a FIFO queue or a LIFO stack.
- Mode is selected at run time and may only change while the buffer is empty.
- Adds registered read data with a valid strobe, simultaneous read/write, count and threshold flags, sticky overflow/underflow/mode-change error flags, and a synchronous flush.
- Sits between a byte/word producer and consumer in the datapath; the existing 8x8 stack/queue usage becomes a WIDTH=8, DEPTH=8 instance.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2. AW = clog2(DEPTH).
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL.
- AE_LEVEL, 1, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- MODE  in  1  requested mode: 0=FIFO, 1=LIFO.
- FLUSH  in  1  synchronous clear of contents and pointers.
- WREN  in  1  write request.
- WR_DATA  in  WIDTH  write data.
- REN  in  1  read request.
- RD_DATA  out  WIDTH  registered read data.
- RD_VALID  out  1  one-cycle pulse; RD_DATA is valid.
- COUNT  out  AW+1  number of stored entries, 0..DEPTH.
- FULL / EMPTY  out  1  COUNT==DEPTH / COUNT==0.
- ALMOST_FULL / ALMOST_EMPTY  out  1  threshold flags.
- ACT_MODE  out  1  mode currently in force.
- OVERFLOW / UNDERFLOW / MODE_ERR  out  1  sticky error flags.
- CLR_ERR  in  1  synchronous clear of sticky error flags.

Behaviour:
- Reset (RST_N low, asynchronous):
  - COUNT, pointers, RD_DATA, RD_VALID, all error flags = 0; ACT_MODE = 0; EMPTY=1.
  - Storage array is not reset; contents are undefined.
- Flags EMPTY, FULL, ALMOST_* are combinational from COUNT.
- Priority per cycle: reset > FLUSH > WREN/REN.
- FLUSH:
  - Next cycle COUNT=0 and pointers=0; WREN/REN ignored that cycle; RD_VALID=0.
  - Error flags and ACT_MODE are unchanged.
- Read latency: a read accepted at edge N gives RD_DATA/RD_VALID=1 after edge N. RD_VALID=0 on cycles with no accepted read. RD_DATA holds its last value otherwise.
- FIFO (ACT_MODE=0):
  - Write stores at WPTR, WPTR+1 mod DEPTH. Read outputs mem[RPTR], RPTR+1 mod DEPTH.
  - All DEPTH entries are usable; pointers wrap freely.
- LIFO (ACT_MODE=1):
  - Top index = COUNT-1. Push writes mem[COUNT]; pop outputs mem[COUNT-1].
- Simultaneous WREN & REN:
  - FIFO, not empty: both accepted, COUNT unchanged; legal when full.
  - LIFO, not empty: RD_DATA = old top, new data overwrites the top slot, COUNT unchanged; legal when full.
  - Empty, either mode: write accepted, read rejected, UNDERFLOW set. No bypass.
- Rejections:
  - WREN alone while FULL: write dropped, OVERFLOW set.
  - REN alone while EMPTY: no RD_VALID, UNDERFLOW set.
- Mode change:
  - ACT_MODE loads MODE on any edge where COUNT==0 and no write is accepted.
  - If MODE!=ACT_MODE while COUNT!=0, ACT_MODE holds and MODE_ERR is set.
  - FLUSH followed by one idle cycle guarantees the switch.
- Sticky flags clear on CLR_ERR. A new error in the same cycle as CLR_ERR wins (flag stays 1).
- COUNT never exceeds DEPTH or wraps below 0.

Test Plan:
- WIDTH=8, DEPTH=8, FIFO: write 0x11..0x88, then 8 reads -> RD_DATA 0x11..0x88 in order, each one cycle after REN. FULL=1 after 8th write. ALMOST_FULL=1 at COUNT=6. EMPTY=1 after last read.
- LIFO: push 0xA1,0xA2,0xA3, pop x3 -> 0xA3,0xA2,0xA1. Then pop on empty -> no RD_VALID, UNDERFLOW=1. CLR_ERR -> UNDERFLOW=0.
- FIFO wrap: loop 20 cycles of simultaneous write k/read with COUNT=4 pre-filled -> outputs lag inputs by exactly 4 entries; COUNT stays 4.
- LIFO full (8 entries, top 0x08): WREN+REN with 0xFF -> RD_DATA=0x08, COUNT=8, next pop returns 0xFF. Write alone when full -> OVERFLOW=1, contents unchanged.
- Mode: MODE=1 with COUNT=3 -> ACT_MODE stays 0, MODE_ERR=1. FLUSH then idle -> COUNT=0, ACT_MODE=1.
- Reset mid-operation: RST_N low asynchronously with COUNT=5 and REN high -> COUNT=0, RD_VALID=0, flags cleared immediately. First read after release is rejected as empty.
